// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache backing-memory responder.
// Provides the responder FSM state encoding, address geometry constants
// and the address-legality check used when a request is accepted.
package cache_mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // An address is illegal when it is not word aligned or when it points
    // past the last word of the backing store (any bit above the index set).
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       mem_words);
        logic [63:0] limit;
        limit = 64'(mem_words) * 64'(WORD_BYTES);
        return (addr[1:0] != 2'b00) || ({32'd0, addr} >= limit);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc_i pulses, sticks at all-ones.
// Latency: count visible the cycle after the increment edge.
// Ports: clk_i/rst_ni clock and async active-low reset, clr_i synchronous
// clear (wins over inc_i), inc_i increment strobe, cnt_o current count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_backing_memory.sv
// Memory-side responder for the write-back cache: services line refills
// (reads) and dirty write-backs (writes) from a word-addressed store.
// Latency: response valid RD_LATENCY/WR_LATENCY cycles after acceptance.
// Backpressure: one transaction in flight; req_ready low from acceptance
// until the cycle after the response handshake; response held until taken.
// Ports: req_* request channel (valid/ready), resp_* response channel
// (valid/ready, rdata is zero for writes and errors), *_count_o saturating
// statistics for good reads, good writes and errored transactions.
module cache_backing_memory
    import cache_mem_pkg::*;
#(
    parameter int MEM_WORDS  = 256,
    parameter int RD_LATENCY = 3,
    parameter int WR_LATENCY = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_write_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [CNT_W-1:0]  rd_count_o,
    output logic [CNT_W-1:0]  wr_count_o,
    output logic [CNT_W-1:0]  err_count_o
);

    localparam int IDX_W   = $clog2(MEM_WORDS);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(RD_LATENCY - 1);
    localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WR_LATENCY - 1);

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    // Latched request
    logic              wr_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q;

    // Response registers
    logic              resp_write_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;

    logic [31:0]       mem_q [MEM_WORDS];

    logic              req_err;
    logic [IDX_W-1:0]  req_idx;
    logic [LAT_W-1:0]  load_val;
    logic              accept;
    logic              commit;
    logic              hshake;

    // Transaction being committed. With a latency of one the commit happens
    // on the acceptance edge itself, so the live request is used instead of
    // the latched copy.
    logic              cur_write;
    logic              cur_err;
    logic [IDX_W-1:0]  cur_idx;
    logic [31:0]       cur_wdata;

    assign req_err  = addr_err(req_addr_i, MEM_WORDS);
    assign req_idx  = req_addr_i[2 +: IDX_W];
    assign load_val = req_write_i ? WR_LOAD : RD_LOAD;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        accept  = 1'b0;
        commit  = 1'b0;
        hshake  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept = 1'b1;
                    lat_d  = load_val;
                    if (load_val == '0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (lat_q == '0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    hshake  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_write = wr_q;
        cur_err   = err_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_write = req_write_i;
            cur_err   = req_err;
            cur_idx   = req_idx;
            cur_wdata = req_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (accept) begin
                wr_q    <= req_write_i;
                err_q   <= req_err;
                idx_q   <= req_idx;
                wdata_q <= req_wdata_i;
            end
            if (commit) begin
                resp_write_q <= cur_write;
                resp_err_q   <= cur_err;
                resp_rdata_q <= (cur_write || cur_err) ? 32'd0 : mem_q[cur_idx];
            end else if (hshake) begin
                resp_write_q <= 1'b0;
                resp_err_q   <= 1'b0;
                resp_rdata_q <= '0;
            end
        end
    end

    // Store contents survive reset; reset only blocks a commit in progress.
    always_ff @(posedge clk_i) begin
        if (reset_ni && commit && cur_write && !cur_err) begin
            mem_q[cur_idx] <= cur_wdata;
        end
    end

    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .clr_i  (1'b0),
        .inc_i  (commit && !cur_write && !cur_err),
        .cnt_o  (rd_count_o)
    );

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .clr_i  (1'b0),
        .inc_i  (commit && cur_write && !cur_err),
        .cnt_o  (wr_count_o)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .clr_i  (1'b0),
        .inc_i  (commit && cur_err),
        .cnt_o  (err_count_o)
    );

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_write_o = resp_write_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_cache_backing_memory.sv
// Bench for cache_backing_memory: directed scenarios plus a randomized run,
// all checked against an array/counter reference of the store.
// Counters are built 4 bits wide so saturation is reachable quickly.
module tb_cache_backing_memory;

    localparam int MW   = 256;
    localparam int RDL  = 3;
    localparam int WRL  = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_ready, resp_write, resp_err;
    logic [31:0]   resp_rdata;
    logic [CW-1:0] rd_count, wr_count, err_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] mm [MW];
    int m_rd, m_wr, m_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_backing_memory #(
        .MEM_WORDS(MW), .RD_LATENCY(RDL), .WR_LATENCY(WRL), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_write_o(resp_write),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .rd_count_o(rd_count), .wr_count_o(wr_count), .err_count_o(err_count)
    );

    // ---------------- reference model ----------------
    function automatic bit ref_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= MW * 4);
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] er, output logic ee);
        ee = ref_err(a);
        er = 32'd0;
        if (ee) m_err = sat_inc(m_err);
        else if (w) begin mm[a / 4] = d; m_wr = sat_inc(m_wr); end
        else begin er = mm[a / 4]; m_rd = sat_inc(m_rd); end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_rd = 0; m_wr = 0; m_err = 0;
    endtask

    // Presents one request, returns cycles from acceptance to resp_valid.
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL req_ready_timeout: req_ready=%b want 1 within 50 cycles", req_ready);
            lat = -1;
            return;
        end
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        // Garbage after acceptance must be ignored
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold,
                        output int lat, output logic [31:0] rd, output logic e, output logic rw);
        issue(w, a, d, lat);
        rd = resp_rdata; e = resp_err; rw = resp_write;
        repeat (hold) @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_write = 1'b0; req_addr = '0; req_wdata = '0;
        #12;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        vectors++; if (resp_write !== 1'b0) begin miscompares++; $display("FAIL reset_resp_write: got %b want 0", resp_write); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        vectors++; if (resp_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
        vectors++; if ({rd_count, wr_count, err_count} !== '0) begin miscompares++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", rd_count, wr_count, err_count); end
        @(posedge clk); #1 rst_n = 1'b1;
        m_rd = 0; m_wr = 0; m_err = 0;
    endtask

    task automatic test_fill();
        int lat; logic [31:0] rd, er, d; logic e, rw, ee;
        for (int i = 0; i < MW; i++) begin
            d = $urandom;
            xact(1'b1, 32'(i * 4), d, 0, lat, rd, e, rw);
            model_txn(1'b1, 32'(i * 4), d, er, ee);
            vectors++; if (lat !== WRL) begin miscompares++; $display("FAIL fill_latency[%0d]: got %0d want %0d", i, lat, WRL); end
            vectors++; if (e !== ee || rw !== 1'b1 || rd !== er) begin miscompares++; $display("FAIL fill_resp[%0d]: got err=%b wr=%b rdata=%h want err=%b wr=1 rdata=%h", i, e, rw, rd, ee, er); end
        end
        vectors++; if (wr_count !== CW'(m_wr)) begin miscompares++; $display("FAIL fill_wr_sat: got %0d want %0d", wr_count, m_wr); end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd, er; logic e, rw, ee;
        do_reset();
        xact(1'b1, 32'h4, 32'hCAFEBABE, 0, lat, rd, e, rw);
        model_txn(1'b1, 32'h4, 32'hCAFEBABE, er, ee);
        vectors++; if (lat !== WRL) begin miscompares++; $display("FAIL wr_latency: got %0d want %0d", lat, WRL); end
        vectors++; if (e !== 1'b0 || rw !== 1'b1) begin miscompares++; $display("FAIL wr_ack: got err=%b wr=%b want err=0 wr=1", e, rw); end
        xact(1'b0, 32'h4, 32'h0, 0, lat, rd, e, rw);
        model_txn(1'b0, 32'h4, 32'h0, er, ee);
        vectors++; if (lat !== RDL) begin miscompares++; $display("FAIL rd_latency: got %0d want %0d", lat, RDL); end
        vectors++; if (rd !== 32'hCAFEBABE || e !== 1'b0 || rw !== 1'b0) begin miscompares++; $display("FAIL raw_data: got %h err=%b wr=%b want cafebabe err=0 wr=0", rd, e, rw); end
        vectors++; if (wr_count !== CW'(1) || rd_count !== CW'(1)) begin miscompares++; $display("FAIL wr_rd_counts: got wr=%0d rd=%0d want 1/1", wr_count, rd_count); end
    endtask

    task automatic test_hold();
        int lat; logic [31:0] er; logic ee;
        issue(1'b0, 32'h8, 32'h0, lat);
        model_txn(1'b0, 32'h8, 32'h0, er, ee);
        for (int k = 0; k < 5; k++) begin
            vectors++; if (resp_valid !== 1'b1 || resp_rdata !== er || req_ready !== 1'b0) begin miscompares++; $display("FAIL hold[%0d]: got valid=%b rdata=%h ready=%b want 1 %h 0", k, resp_valid, resp_rdata, req_ready, er); end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1; #1;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL hshake_cycle_ready: got %b want 0", req_ready); end
        @(posedge clk); #1 resp_ready = 1'b0;
        vectors++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL after_hshake: got ready=%b valid=%b want 1 0", req_ready, resp_valid); end
        vectors++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0 || resp_write !== 1'b0) begin miscompares++; $display("FAIL resp_clear: got rdata=%h err=%b wr=%b want 0", resp_rdata, resp_err, resp_write); end
    endtask

    task automatic test_addr_err();
        int lat; logic [31:0] rd, er; logic e, rw, ee;
        do_reset();
        xact(1'b0, 32'h6, 32'h0, 0, lat, rd, e, rw);
        model_txn(1'b0, 32'h6, 32'h0, er, ee);
        vectors++; if (e !== 1'b1 || rd !== 32'd0 || lat !== RDL) begin miscompares++; $display("FAIL err_misaligned: got err=%b rdata=%h lat=%0d want 1 0 %0d", e, rd, lat, RDL); end
        xact(1'b1, 32'h400, 32'hDEADBEEF, 0, lat, rd, e, rw);
        model_txn(1'b1, 32'h400, 32'hDEADBEEF, er, ee);
        vectors++; if (e !== 1'b1 || rd !== 32'd0 || rw !== 1'b1) begin miscompares++; $display("FAIL err_range: got err=%b rdata=%h wr=%b want 1 0 1", e, rd, rw); end
        vectors++; if (err_count !== CW'(2) || rd_count !== '0 || wr_count !== '0) begin miscompares++; $display("FAIL err_counts: got err=%0d rd=%0d wr=%0d want 2 0 0", err_count, rd_count, wr_count); end
        for (int i = 0; i < 2; i++) begin
            xact(1'b0, 32'(i * 4), 32'h0, 0, lat, rd, e, rw);
            model_txn(1'b0, 32'(i * 4), 32'h0, er, ee);
            vectors++; if (rd !== er) begin miscompares++; $display("FAIL err_mem_unchanged[%0d]: got %h want %h", i, rd, er); end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, n; logic [31:0] rd, er; logic e, rw, ee;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hC; req_wdata = 32'h12345678;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset: got ready=%b valid=%b want 1 0", req_ready, resp_valid); end
        vectors++; if ({rd_count, wr_count, err_count} !== '0) begin miscompares++; $display("FAIL reset_mid_counts: got %0d/%0d/%0d want 0/0/0", rd_count, wr_count, err_count); end
        @(posedge clk); #1 rst_n = 1'b1;
        m_rd = 0; m_wr = 0; m_err = 0;
        xact(1'b0, 32'hC, 32'h0, 0, lat, rd, e, rw);
        model_txn(1'b0, 32'hC, 32'h0, er, ee);
        vectors++; if (rd !== er) begin miscompares++; $display("FAIL aborted_write: got %h want %h", rd, er); end
    endtask

    task automatic test_back_to_back();
        int n, t1, t2, lat; logic [31:0] d0, d1, rd, er; logic e, rw, ee;
        d0 = $urandom; d1 = $urandom;
        resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = d0;
        @(posedge clk); #1;
        t1 = cyc; req_addr = 32'h14; req_wdata = d1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        t2 = cyc; req_valid = 1'b0;
        vectors++; if (t2 - t1 !== WRL + 2) begin miscompares++; $display("FAIL b2b_interval: got %0d want %0d", t2 - t1, WRL + 2); end
        n = 0;
        while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1 resp_ready = 1'b0;
        model_txn(1'b1, 32'h10, d0, er, ee);
        model_txn(1'b1, 32'h14, d1, er, ee);
        for (int i = 0; i < 2; i++) begin
            xact(1'b0, 32'h10 + 32'(i * 4), 32'h0, 0, lat, rd, e, rw);
            model_txn(1'b0, 32'h10 + 32'(i * 4), 32'h0, er, ee);
            vectors++; if (rd !== er) begin miscompares++; $display("FAIL b2b_readback[%0d]: got %h want %h", i, rd, er); end
        end
    endtask

    task automatic test_random();
        int lat, mode; bit w; logic [31:0] a, d, rd, er; logic e, rw, ee;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom);
            d = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) a = 32'($urandom_range(0, MW * 4 - 1)) | 32'h1;
            else if (mode == 1) a = ($urandom | 32'h400) & ~32'h3;
            else a = 32'($urandom_range(0, MW - 1)) * 4;
            xact(w, a, d, $urandom_range(0, 3), lat, rd, e, rw);
            model_txn(w, a, d, er, ee);
            vectors++; if (lat !== (w ? WRL : RDL)) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, w ? WRL : RDL); end
            vectors++; if (rd !== er || e !== ee || rw !== w) begin miscompares++; $display("FAIL rand_resp[%0d] addr=%h: got rdata=%h err=%b wr=%b want %h %b %b", i, a, rd, e, rw, er, ee, w); end
            vectors++; if (rd_count !== CW'(m_rd) || wr_count !== CW'(m_wr) || err_count !== CW'(m_err)) begin miscompares++; $display("FAIL rand_counts[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i, rd_count, wr_count, err_count, m_rd, m_wr, m_err); end
        end
    endtask

    task automatic test_saturation();
        int lat; logic [31:0] a, rd, er; logic e, rw, ee;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            a = 32'($urandom_range(0, MW - 1)) * 4;
            xact(1'b0, a, 32'h0, 0, lat, rd, e, rw);
            model_txn(1'b0, a, 32'h0, er, ee);
            vectors++; if (rd_count !== CW'(m_rd) || rd !== er) begin miscompares++; $display("FAIL sat_step[%0d]: got cnt=%0d rdata=%h want %0d %h", i, rd_count, rd, m_rd, er); end
        end
        vectors++; if (rd_count !== CW'(CMAX)) begin miscompares++; $display("FAIL sat_final: got %0d want %0d", rd_count, CMAX); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_hold();
        test_addr_err();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
